br_resolve_ctrl: RTL and testbench
==================================

// Module: br_resolve_ctrl
// PURPOSE
// EX-stage branch/jump resolution controller. Sequences the shared branch comparator,
// evaluates branch conditions and checks them against the fetch-stage prediction.
// On a mispredict it issues a one-cycle PC redirect and squashes wrong-path instructions.
// Also emits BHT training writes and keeps saturating branch/mispredict counters.
// PARAMETERS
// XLEN        32  datapath / PC width
// KILL_CYCLES 2   cycles kill_o stays high, counting the redirect cycle (>=1)
// CNT_W       16  width of the statistics counters
// PORTS
// clk_i          in   1     clock, single domain
// rst_ni         in   1     asynchronous reset, active-low
// stall_i        in   1     hazard-unit stall; blocks accept, freezes KILL countdown
// valid_i        in   1     EX-stage instruction valid
// ready_o        out  1     controller can accept (state==IDLE)
// is_branch_i    in   1     conditional branch
// is_jal_i       in   1     JAL
// is_jalr_i      in   1     JALR
// funct3_i       in   3     branch condition code
// pc_i           in   XLEN  instruction PC
// imm_i          in   XLEN  sign-extended immediate
// rs1_i, rs2_i   in   XLEN  forwarded operands
// pred_taken_i   in   1     fetch-stage prediction: taken
// pred_target_i  in   XLEN  fetch-stage predicted target
// cmp_a_o,cmp_b_o out XLEN  comparator operands (combinational = rs1_i, rs2_i)
// cmp_unsigned_o out  1     comparator unsigned select (combinational = funct3_i[1])
// cmp_less_i     in   1     comparator less result, same cycle
// cmp_equal_i    in   1     comparator equal result, same cycle
// redirect_o     out  1     one-cycle PC redirect pulse
// redirect_pc_o  out  XLEN  corrected PC; holds until next redirect
// kill_o         out  1     squash younger (IF/ID) instructions
// bht_we_o       out  1     one-cycle BHT update strobe
// bht_pc_o       out  XLEN  PC of the trained branch
// bht_taken_o    out  1     resolved direction
// br_cnt_o       out  CNT_W legal conditional branches resolved (saturating)
// mispred_cnt_o  out  CNT_W redirects issued (saturating)
// BEHAVIOUR
// - fire = valid_i & ready_o & ~stall_i. Type priority: jal > jalr > branch; no flag set -> consumed, no action.
// - Conditions on funct3: 000 eq, 001 ~eq, 100/110 less, 101/111 ~less.
//   010/011 are illegal: not taken, no redirect, no BHT write, no count.
// - Targets mod 2^XLEN: JAL pc+imm; JALR (rs1+imm)&~1; taken branch pc+imm; not-taken pc+4.
// - Mispredict for a branch: taken!=pred_taken_i, or (taken & pred_target_i!=target).
//   Mispredict for JAL/JALR: ~pred_taken_i, or pred_target_i!=target.
// - All non-comparator outputs are registered: 1-cycle latency after fire.
// - FSM: IDLE -> REDIR on mispredicting fire, else stay in IDLE.
//   REDIR (always exactly 1 cycle, ignores stall_i): redirect_o=1, kill_o=1, ready_o=0.
//   REDIR -> KILL with cnt=KILL_CYCLES-1 when KILL_CYCLES>1, else -> IDLE.
//   KILL: kill_o=1, ready_o=0; cnt decrements only when ~stall_i; cnt==1 & ~stall_i -> IDLE.
// - valid_i while ready_o=0 is ignored (upstream holds the instruction; no action, no count).
// - BHT: a legal conditional branch fire gives, next cycle, bht_we_o=1, bht_pc_o=pc_i, bht_taken_o=taken.
//   JAL/JALR never write the BHT. bht_pc_o/bht_taken_o hold their value when bht_we_o=0.
// - br_cnt_o +1 per legal branch fire; mispred_cnt_o +1 per REDIR entry; both stick at all-ones.
// - Reset (async, rst_ni=0): state IDLE; every output register, including all counters, goes to 0.
//   Reset asserted mid-REDIR/KILL drops redirect_o/kill_o immediately; ready_o=1 once rst_ni releases.
// TESTING
// 1 BLT rs1=0xFFFFFFFF rs2=1 pc=0x100 imm=0x20 pred_taken=0 -> cmp_unsigned_o=0; next cycle
//   redirect_o=1, redirect_pc_o=0x120, bht_taken_o=1; kill_o high 2 cycles; ready_o low 2 cycles.
// 2 BLTU same operands, pred_taken=0 -> not taken, no redirect; bht_we_o=1, bht_taken_o=0; br_cnt_o=1.
// 3 JALR rs1=0x1003 imm=4 pred_taken=1: pred_target=0x1006 -> no redirect;
//   pred_target=0x1004 -> redirect_pc_o=0x1006, mispred_cnt_o +1.
// 4 valid_i held high during KILL with stall_i high for 3 cycles -> not accepted;
//   kill_o lasts 2+3 cycles; instruction accepted on return to IDLE.
// 5 branch funct3=010, pred_taken=1 -> no redirect, no bht_we_o, counters unchanged.
// 6 rst_ni=0 mid-KILL -> kill_o/redirect_o=0 asynchronously; with CNT_W=4, 20 mispredicts -> mispred_cnt_o=0xF.

Source files
------------

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch/jump resolution: evaluates conditions on the shared comparator,
// detects mispredicts, sequences redirect/squash and emits BHT training and statistics.
module br_resolve_ctrl #(
  parameter int XLEN        = 32,
  parameter int KILL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  output logic [XLEN-1:0]  cmp_a_o,
  output logic [XLEN-1:0]  cmp_b_o,
  output logic             cmp_unsigned_o,
  input  logic             cmp_less_i,
  input  logic             cmp_equal_i,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             kill_o,
  output logic             bht_we_o,
  output logic [XLEN-1:0]  bht_pc_o,
  output logic             bht_taken_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int KW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIR, KILL} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     kcnt_q, kcnt_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              bht_we_q, bht_we_d;
  logic [XLEN-1:0]   bht_pc_q, bht_pc_d;
  logic              bht_taken_q, bht_taken_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic              fire;
  logic              jal_sel, jalr_sel, br_sel, br_legal, br_taken;
  logic [XLEN-1:0]   pc_plus_imm, pc_plus_4, jalr_tgt, target;
  logic              mispredict;

  assign cmp_a_o        = rs1_i;
  assign cmp_b_o        = rs2_i;
  assign cmp_unsigned_o = funct3_i[1];

  assign ready_o = (state_q == IDLE);
  assign fire    = valid_i & ready_o & ~stall_i;

  // Type priority jal > jalr > branch; 010/011 are not branch conditions.
  assign br_legal = (funct3_i[2:1] != 2'b01);
  assign jal_sel  = is_jal_i;
  assign jalr_sel = ~is_jal_i & is_jalr_i;
  assign br_sel   = ~is_jal_i & ~is_jalr_i & is_branch_i & br_legal;

  always_comb begin
    br_taken = 1'b0;
    case (funct3_i)
      3'b000:          br_taken = cmp_equal_i;
      3'b001:          br_taken = ~cmp_equal_i;
      3'b100, 3'b110:  br_taken = cmp_less_i;
      3'b101, 3'b111:  br_taken = ~cmp_less_i;
      default:         br_taken = 1'b0;
    endcase
  end

  assign pc_plus_imm = pc_i + imm_i;
  assign pc_plus_4   = pc_i + XLEN'(4);
  assign jalr_tgt    = (rs1_i + imm_i) & ~XLEN'(1);

  always_comb begin
    target     = pc_plus_4;
    mispredict = 1'b0;
    if (jal_sel) begin
      target     = pc_plus_imm;
      mispredict = ~pred_taken_i | (pred_target_i != target);
    end else if (jalr_sel) begin
      target     = jalr_tgt;
      mispredict = ~pred_taken_i | (pred_target_i != target);
    end else if (br_sel) begin
      target     = br_taken ? pc_plus_imm : pc_plus_4;
      mispredict = (br_taken != pred_taken_i) | (br_taken & (pred_target_i != target));
    end
  end

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    redir_pc_d  = redir_pc_q;
    bht_we_d    = 1'b0;
    bht_pc_d    = bht_pc_q;
    bht_taken_d = bht_taken_q;
    br_cnt_d    = br_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (br_sel) begin
            bht_we_d    = 1'b1;
            bht_pc_d    = pc_i;
            bht_taken_d = br_taken;
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
          end
          if (mispredict) begin
            state_d    = REDIR;
            redir_pc_d = target;
            if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
          end
        end
      end
      // The redirect cycle is never stretched by a stall.
      REDIR: begin
        if (KILL_CYCLES > 1) begin
          state_d = KILL;
          kcnt_d  = KW'(KILL_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      KILL: begin
        if (!stall_i) begin
          if (kcnt_q == KW'(1)) state_d = IDLE;
          kcnt_d = kcnt_q - KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      kcnt_q      <= '0;
      redir_pc_q  <= '0;
      bht_we_q    <= 1'b0;
      bht_pc_q    <= '0;
      bht_taken_q <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      redir_pc_q  <= redir_pc_d;
      bht_we_q    <= bht_we_d;
      bht_pc_q    <= bht_pc_d;
      bht_taken_q <= bht_taken_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign redirect_o    = (state_q == REDIR);
  assign kill_o        = (state_q != IDLE);
  assign redirect_pc_o = redir_pc_q;
  assign bht_we_o      = bht_we_q;
  assign bht_pc_o      = bht_pc_q;
  assign bht_taken_o   = bht_taken_q;
  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: an abstract model checked every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_br_resolve_ctrl;
  localparam int XLEN = 32;
  localparam int KC   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stall = 1'b0, valid = 1'b0, ready;
  logic is_br = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic [2:0] f3 = '0;
  logic [XLEN-1:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0, ptgt = '0;
  logic pt = 1'b0;
  logic [XLEN-1:0] cmp_a, cmp_b, redir_pc, bht_pc;
  logic cmp_uns, cmp_less, cmp_eq, redir, kill, bht_we, bht_taken;
  logic [CW-1:0] br_cnt, mis_cnt;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  // External comparator
  assign cmp_less = cmp_uns ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
  assign cmp_eq   = (cmp_a == cmp_b);

  br_resolve_ctrl #(.XLEN(XLEN), .KILL_CYCLES(KC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .valid_i(valid), .ready_o(ready),
    .is_branch_i(is_br), .is_jal_i(is_jal), .is_jalr_i(is_jalr), .funct3_i(f3),
    .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .rs2_i(rs2),
    .pred_taken_i(pt), .pred_target_i(ptgt),
    .cmp_a_o(cmp_a), .cmp_b_o(cmp_b), .cmp_unsigned_o(cmp_uns),
    .cmp_less_i(cmp_less), .cmp_equal_i(cmp_eq),
    .redirect_o(redir), .redirect_pc_o(redir_pc), .kill_o(kill),
    .bht_we_o(bht_we), .bht_pc_o(bht_pc), .bht_taken_o(bht_taken),
    .br_cnt_o(br_cnt), .mispred_cnt_o(mis_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- abstract model ----------------
  logic m_redir, m_bht_we, m_bht_taken;
  int m_kill_left, m_br, m_mis;
  logic [XLEN-1:0] m_redir_pc, m_bht_pc;

  function automatic logic cond_taken(input logic [2:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic lt;
    lt = c[1] ? (a < b) : ($signed(a) < $signed(b));
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic busy, mis, tk;
    logic [XLEN-1:0] tgt;
    if (!rst_n) begin
      m_redir = 0; m_kill_left = 0; m_br = 0; m_mis = 0;
      m_redir_pc = '0; m_bht_we = 0; m_bht_pc = '0; m_bht_taken = 0;
    end else begin
      busy = m_redir || (m_kill_left > 0);
      m_bht_we = 0;
      mis = 0;
      tgt = '0;
      if (m_redir) begin
        m_redir = 0;
        m_kill_left = KC - 1;
      end else if (m_kill_left > 0) begin
        if (!stall) m_kill_left--;
      end else if (valid && !busy && !stall) begin
        if (is_jal) begin
          tgt = pc + imm;
          mis = !pt || (ptgt != tgt);
        end else if (is_jalr) begin
          tgt = (rs1 + imm) & 32'hFFFF_FFFE;
          mis = !pt || (ptgt != tgt);
        end else if (is_br && f3 != 3'd2 && f3 != 3'd3) begin
          tk = cond_taken(f3, rs1, rs2);
          tgt = tk ? pc + imm : pc + 4;
          mis = (tk != pt) || (tk && ptgt != tgt);
          m_bht_we = 1; m_bht_pc = pc; m_bht_taken = tk;
          m_br = (m_br >= MAXC) ? MAXC : m_br + 1;
        end
        if (mis) begin
          m_redir = 1;
          m_redir_pc = tgt;
          m_mis = (m_mis >= MAXC) ? MAXC : m_mis + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", ready, !(m_redir || m_kill_left > 0));
      chk("redirect", redir, m_redir);
      chk("kill", kill, m_redir || m_kill_left > 0);
      chk("redirect_pc", redir_pc, m_redir_pc);
      chk("bht_we", bht_we, m_bht_we);
      chk("bht_pc", bht_pc, m_bht_pc);
      chk("bht_taken", bht_taken, m_bht_taken);
      chk("br_cnt", br_cnt, m_br);
      chk("mispred_cnt", mis_cnt, m_mis);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_instr(input logic b, input logic j, input logic jr, input logic [2:0] c,
                           input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                           input logic [31:0] bb, input logic ptk, input logic [31:0] ptg);
    is_br = b; is_jal = j; is_jalr = jr; f3 = c; pc = p; imm = im;
    rs1 = a; rs2 = bb; pt = ptk; ptgt = ptg;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    if (!ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got 0x0 expected 0x1");
    end
  endtask

  // Present the current instruction for exactly one accepted cycle.
  task automatic issue();
    wait_ready();
    valid = 1'b1;
    #1;
    chk("cmp_a", cmp_a, rs1);
    chk("cmp_b", cmp_b, rs2);
    chk("cmp_unsigned", cmp_uns, f3[1]);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kc, rc, bcyc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_kill", kill, 0);
    chk("reset_br_cnt", br_cnt, 0);
    chk("reset_mis_cnt", mis_cnt, 0);
    chk("reset_redir_pc", redir_pc, 0);

    // 1: BLT -1 < 1 signed, predicted not taken
    do_reset();
    set_instr(1, 0, 0, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
    #1 chk("t1_cmp_unsigned", cmp_uns, 0);
    issue();
    chk("t1_redirect", redir, 1);
    chk("t1_redirect_pc", redir_pc, 32'h120);
    chk("t1_bht_taken", bht_taken, 1);
    chk("t1_bht_we", bht_we, 1);
    kc = kill; rc = !ready;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      kc += kill; rc += !ready;
    end
    chk("t1_kill_cycles", kc, 2);
    chk("t1_ready_low_cycles", rc, 2);

    // 2: BLTU 0xFFFFFFFF < 1 unsigned -> not taken, correctly predicted
    do_reset();
    set_instr(1, 0, 0, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
    issue();
    chk("t2_redirect", redir, 0);
    chk("t2_bht_we", bht_we, 1);
    chk("t2_bht_taken", bht_taken, 0);
    chk("t2_br_cnt", br_cnt, 1);

    // 3: JALR target (0x1003+4)&~1 = 0x1006
    do_reset();
    set_instr(0, 0, 1, 3'b000, 32'h50, 32'h4, 32'h1003, 32'h0, 1, 32'h1006);
    issue();
    chk("t3a_redirect", redir, 0);
    chk("t3a_mis_cnt", mis_cnt, 0);
    ptgt = 32'h1004;
    issue();
    chk("t3b_redirect", redir, 1);
    chk("t3b_redirect_pc", redir_pc, 32'h1006);
    chk("t3b_mis_cnt", mis_cnt, 1);
    chk("t3b_bht_we", bht_we, 0);

    // 5: illegal funct3 010 is inert
    set_instr(1, 0, 0, 3'b010, 32'h400, 32'h10, 32'h0, 32'h0, 1, 32'h500);
    issue();
    chk("t5_redirect", redir, 0);
    chk("t5_bht_we", bht_we, 0);
    chk("t5_br_cnt", br_cnt, 0);
    chk("t5_mis_cnt", mis_cnt, 1);

    // Extra patterns: not-taken mispredict, wrong target, BGE, priority, no-type
    set_instr(1, 0, 0, 3'b001, 32'h600, 32'h40, 32'h7, 32'h7, 1, 32'h640);
    issue();
    chk("bne_redirect_pc", redir_pc, 32'h604);
    set_instr(1, 0, 0, 3'b000, 32'h700, 32'h40, 32'h9, 32'h9, 1, 32'h0);
    issue();
    chk("beq_tgt_redirect_pc", redir_pc, 32'h740);
    chk("beq_tgt_mis_cnt", mis_cnt, 3);
    set_instr(1, 0, 0, 3'b101, 32'h780, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
    issue();
    chk("bge_bht_taken", bht_taken, 0);
    chk("bge_redirect", redir, 0);
    set_instr(1, 1, 1, 3'b000, 32'h800, 32'h10, 32'h1, 32'h1, 1, 32'h810);
    issue();
    chk("prio_redirect", redir, 0);
    chk("prio_bht_we", bht_we, 0);
    set_instr(0, 0, 0, 3'b000, 32'h900, 32'h10, 32'h0, 32'h0, 0, 32'h0);
    issue();
    chk("none_redirect", redir, 0);
    chk("none_br_cnt", br_cnt, 3);

    // 4: valid held through KILL with a 3-cycle stall
    wait_ready();
    set_instr(0, 1, 0, 3'b000, 32'h200, 32'h8, 32'h0, 32'h0, 0, 32'h0);
    valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_instr(1, 0, 0, 3'b000, 32'h300, 32'h10, 32'h5, 32'h5, 1, 32'h310);
    kc = kill; bcyc = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 1) stall = 1'b1;
      if (cyc == 4) stall = 1'b0;
      kc += kill;
      if (bht_we && bcyc < 0) begin
        bcyc = cyc;
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk("t4_kill_cycles", kc, 5);
    chk("t4_accept_cycle", bcyc, 6);
    chk("t4_bht_pc", bht_pc, 32'h300);

    // 6: async reset mid-KILL, then counter saturation
    set_instr(0, 1, 0, 3'b000, 32'hA00, 32'h8, 32'h0, 32'h0, 0, 32'h0);
    issue();
    @(posedge clk); @(negedge clk);
    chk("t6_kill_before_reset", kill, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_kill_async", kill, 0);
    chk("t6_redirect_async", redir, 0);
    chk("t6_mis_cnt_reset", mis_cnt, 0);
    chk("t6_br_cnt_reset", br_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_ready_after_reset", ready, 1);
    for (int i = 0; i < 20; i++) begin
      set_instr(0, 1, 0, 3'b000, 32'hB00 + 32'(i) * 4, 32'h10, 32'h0, 32'h0, 0, 32'h0);
      issue();
    end
    chk("t6_mis_cnt_sat", mis_cnt, 32'hF);
    for (int i = 0; i < 20; i++) begin
      set_instr(1, 0, 0, 3'b000, 32'hC00, 32'h10, 32'h3, 32'h3, 1, 32'hC10);
      issue();
    end
    chk("t6_br_cnt_sat", br_cnt, 32'hF);
    chk("t6_mis_cnt_hold", mis_cnt, 32'hF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
